modulo_display_bcd_3_digitos_multiplexado: RTL and testbench

Downstream consumer of the 7-bit up/down counter's q bus. Converts the unsigned count (0..127) to three BCD digits with a sequential shift-add-3 (double-dabble) FSM. Time-multiplexes the digits onto one common 7-segment bus with active-low anodes. Drives the board display directly.

---
 rtl/modulo_display_bcd_3_digitos_multiplexado_pkg.sv | 34 +++
 rtl/modulo_display_bcd_3_digitos_multiplexado_decodificador_bcd_7seg.sv | 26 ++
 rtl/modulo_display_bcd_3_digitos_multiplexado.sv | 125 ++++++++++++
 tb/tb_modulo_display_bcd_3_digitos_multiplexado.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/modulo_display_bcd_3_digitos_multiplexado_pkg.sv
// rtl/modulo_display_bcd_3_digitos_multiplexado_pkg.sv - shared constants for the 3-digit BCD display
package modulo_display_bcd_3_digitos_multiplexado_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  localparam int N_ITER = 7;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [2:0] AN_OFF = 3'b111;

  function automatic logic [11:0] add3_nibbles(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/modulo_display_bcd_3_digitos_multiplexado_decodificador_bcd_7seg.sv
// rtl/modulo_display_bcd_3_digitos_multiplexado_decodificador_bcd_7seg.sv - BCD to active-low 7-segment
module decodificador_bcd_7seg
  import modulo_display_bcd_3_digitos_multiplexado_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/modulo_display_bcd_3_digitos_multiplexado.sv
// rtl/modulo_display_bcd_3_digitos_multiplexado.sv - binary to BCD converter with multiplexed 3-digit display
module modulo_display_bcd_3_digitos_multiplexado
  import modulo_display_bcd_3_digitos_multiplexado_pkg::*;
#(
  parameter int REFRESH_DIV   = 50000,
  parameter int BLANK_LEADING = 1
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [6:0]  q_in,
  output logic        busy,
  output logic        valid,
  output logic [11:0] bcd_out,
  output logic [6:0]  seg,
  output logic [2:0]  an
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  logic [1:0]    state;
  logic [6:0]    shadow;
  logic [6:0]    bin_sr;
  logic [11:0]   bcd_sr;
  logic [2:0]    iter;
  logic [CW-1:0] refresh_cnt;
  logic [1:0]    digit_sel;
  logic [3:0]    digit;
  logic [6:0]    dec_seg;
  logic          blank;
  logic [2:0]    an_pat;

  // Shadow compare in IDLE guarantees the last stable input is always converted
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state   <= ST_IDLE;
      shadow  <= '0;
      bin_sr  <= '0;
      bcd_sr  <= '0;
      iter    <= '0;
      bcd_out <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if ((q_in != shadow) || !valid) begin
            shadow <= q_in;
            bin_sr <= q_in;
            bcd_sr <= '0;
            iter   <= '0;
            state  <= ST_SHIFT;
            busy   <= 1'b1;
          end
        end
        ST_SHIFT: begin
          {bcd_sr, bin_sr} <= {add3_nibbles(bcd_sr), bin_sr} << 1;
          iter <= iter + 3'd1;
          if (iter == 3'(N_ITER - 1)) state <= ST_DONE;
        end
        ST_DONE: begin
          bcd_out <= bcd_sr;
          valid   <= 1'b1;
          state   <= ST_IDLE;
          busy    <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'd0;
    end else if (refresh_cnt == TERM) begin
      refresh_cnt <= '0;
      digit_sel   <= (digit_sel == 2'd2) ? 2'd0 : digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  always_comb begin
    digit  = bcd_out[3:0];
    an_pat = 3'b110;
    blank  = !valid;
    case (digit_sel)
      2'd1: begin
        digit  = bcd_out[7:4];
        an_pat = 3'b101;
        if ((BLANK_LEADING != 0) && (bcd_out[11:8] == 4'd0) && (bcd_out[7:4] == 4'd0)) blank = 1'b1;
      end
      2'd2: begin
        digit  = bcd_out[11:8];
        an_pat = 3'b011;
        if ((BLANK_LEADING != 0) && (bcd_out[11:8] == 4'd0)) blank = 1'b1;
      end
      2'd3: begin
        an_pat = AN_OFF;
        blank  = 1'b1;
      end
      default: ;
    endcase
  end

  decodificador_bcd_7seg u_dec (
    .bcd (digit),
    .seg (dec_seg)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= blank ? AN_OFF : an_pat;
      seg <= blank ? SEG_BLANK : dec_seg;
    end
  end

endmodule

// File: tb/tb_modulo_display_bcd_3_digitos_multiplexado.sv
// tb/tb_modulo_display_bcd_3_digitos_multiplexado.sv - directed bench for the 3-digit BCD display
module tb_modulo_display_bcd_3_digitos_multiplexado;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [6:0]  q_in = 7'd0;
  logic        busy, valid, busy0, valid0;
  logic [11:0] bcd_out, bcd_out0;
  logic [6:0]  seg, seg0;
  logic [2:0]  an, an0;

  int vectors = 0;
  int miscompares = 0;
  int n = 0;
  logic bad;

  always #5 clk = ~clk;

  // Edges since reset release; refresh slot after edge n is floor((n-1)/4) mod 3
  always @(posedge clk or negedge clr) begin
    if (!clr) n <= 0;
    else n <= n + 1;
  end

  modulo_display_bcd_3_digitos_multiplexado #(.REFRESH_DIV(4), .BLANK_LEADING(1)) dut (
    .clk(clk), .clr(clr), .q_in(q_in), .busy(busy), .valid(valid),
    .bcd_out(bcd_out), .seg(seg), .an(an)
  );

  modulo_display_bcd_3_digitos_multiplexado #(.REFRESH_DIV(4), .BLANK_LEADING(0)) dut0 (
    .clk(clk), .clr(clr), .q_in(q_in), .busy(busy0), .valid(valid0),
    .bcd_out(bcd_out0), .seg(seg0), .an(an0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Advance to just after an edge n = 12m+1, where the units slot has just been loaded
  task automatic align();
    int g;
    g = 0;
    do begin
      @(negedge clk);
      g++;
    end while (((n % 12) != 1) && (g < 30));
  endtask

  initial begin
    // Reset state
    step(2);
    chk("rst_an", 32'(an), 32'(3'b111));
    chk("rst_seg", 32'(seg), 32'(7'b1111111));
    chk("rst_bcd", 32'(bcd_out), 32'h000);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    // Release with q_in=0: capture at edge 1, result at edge 9
    clr = 1'b1;
    step(1);
    chk("q0_busy_e1", 32'(busy), 32'd1);
    step(7);
    chk("q0_valid_e8", 32'(valid), 32'd0);
    step(1);
    chk("q0_valid_e9", 32'(valid), 32'd1);
    chk("q0_bcd", 32'(bcd_out), 32'h000);
    chk("q0_busy_e9", 32'(busy), 32'd0);
    align();
    chk("q0_units_an", 32'(an), 32'(3'b110));
    chk("q0_units_seg", 32'(seg), 32'(7'b1000000));
    step(4);
    chk("q0_tens_an", 32'(an), 32'(3'b111));
    chk("q0_tens_seg", 32'(seg), 32'(7'b1111111));
    step(4);
    chk("q0_hund_an", 32'(an), 32'(3'b111));

    // 127
    q_in = 7'd127;
    step(8);
    chk("q127_bcd_k7", 32'(bcd_out), 32'h000);
    chk("q127_busy", 32'(busy), 32'd1);
    step(1);
    chk("q127_bcd_k8", 32'(bcd_out), 32'h127);
    for (int r = 0; r < 2; r++) begin
      align();
      chk("q127_units_an", 32'(an), 32'(3'b110));
      chk("q127_units_seg", 32'(seg), 32'(7'b1111000));
      step(4);
      chk("q127_tens_an", 32'(an), 32'(3'b101));
      chk("q127_tens_seg", 32'(seg), 32'(7'b0100100));
      step(4);
      chk("q127_hund_an", 32'(an), 32'(3'b011));
      chk("q127_hund_seg", 32'(seg), 32'(7'b1111001));
    end

    // 100: tens zero but shown because hundreds is nonzero
    q_in = 7'd100;
    step(9);
    chk("q100_bcd", 32'(bcd_out), 32'h100);
    align();
    chk("q100_units_seg", 32'(seg), 32'(7'b1000000));
    step(4);
    chk("q100_tens_an", 32'(an), 32'(3'b101));
    chk("q100_tens_seg", 32'(seg), 32'(7'b1000000));
    step(4);
    chk("q100_hund_seg", 32'(seg), 32'(7'b1111001));

    // 45 then 99 while busy
    q_in = 7'd45;
    step(3);
    q_in = 7'd99;
    chk("q45_busy", 32'(busy), 32'd1);
    step(5);
    chk("q45_bcd_k7", 32'(bcd_out), 32'h100);
    step(1);
    chk("q45_bcd_k8", 32'(bcd_out), 32'h045);
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1);
      if (bcd_out !== 12'h045) bad = 1'b1;
    end
    chk("q45_hold", 32'(bad), 32'd0);
    step(1);
    chk("q99_bcd", 32'(bcd_out), 32'h099);

    // Async reset during SHIFT iteration 3
    q_in = 7'd88;
    step(4);
    chk("q88_busy_mid", 32'(busy), 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("arst_bcd", 32'(bcd_out), 32'h000);
    chk("arst_valid", 32'(valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_an", 32'(an), 32'(3'b111));
    chk("arst_seg", 32'(seg), 32'(7'b1111111));
    step(1);
    clr = 1'b1;
    step(1);
    chk("q88_busy_e1", 32'(busy), 32'd1);
    step(7);
    chk("q88_bcd_e8", 32'(bcd_out), 32'h000);
    step(1);
    chk("q88_bcd_e9", 32'(bcd_out), 32'h088);

    // 5: leading zeros shown on the BLANK_LEADING=0 instance only
    q_in = 7'd5;
    step(9);
    chk("q5_bcd0", 32'(bcd_out0), 32'h005);
    align();
    chk("q5_units_an0", 32'(an0), 32'(3'b110));
    chk("q5_units_seg0", 32'(seg0), 32'(7'b0010010));
    step(4);
    chk("q5_tens_an0", 32'(an0), 32'(3'b101));
    chk("q5_tens_seg0", 32'(seg0), 32'(7'b1000000));
    chk("q5_tens_an_blank", 32'(an), 32'(3'b111));
    step(4);
    chk("q5_hund_an0", 32'(an0), 32'(3'b011));
    chk("q5_hund_seg0", 32'(seg0), 32'(7'b1000000));
    chk("q5_hund_an_blank", 32'(an), 32'(3'b111));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
